// File: rtl/cci_host_mem_responder.sv
// ---------------------------------------------------------------------------
// cci_host_mem_responder
//
// Host-side stand-in for the FIU plus host memory on CCI-P style channels.
// c0 reads are answered from an internal line memory after a fixed
// RD_LATENCY-cycle shift pipeline. c1 writes update that memory on the
// accepting edge and are acked one cycle later.
//
// Optional feature macro: CCI_RSP_ADDR_CHECK_EN
//   defined   : addresses >= 2**ADDR_WIDTH set the sticky err flag. Such reads
//               return zero data, and such writes are acked but dropped.
//   undefined : addresses wrap modulo 2**ADDR_WIDTH, and err is tied to 0.
//
// Ports
//   clk, reset_n                      clock, async active-low reset
//   c0_req_valid/addr/mdata           read request (accepted every cycle)
//   c0_almfull                        read backpressure (registered)
//   c0_rsp_valid/mdata/data           read response
//   c1_req_valid/addr/mdata/data      write request (accepted every cycle)
//   c1_almfull                        write backpressure (always 0)
//   c1_rsp_valid/mdata                write ack
//   dbg_addr/dbg_data                 combinational memory peek
//   err                               sticky address-range error
// ---------------------------------------------------------------------------
module cci_host_mem_responder #(
    parameter int ADDR_WIDTH  = 4,
    parameter int CL_ADDR_W   = 42,
    parameter int MDATA_W     = 16,
    parameter int RD_LATENCY  = 4,
    parameter int ALMFULL_THR = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  c0_req_valid,
    input  logic [CL_ADDR_W-1:0]  c0_req_addr,
    input  logic [MDATA_W-1:0]    c0_req_mdata,
    output logic                  c0_almfull,
    output logic                  c0_rsp_valid,
    output logic [MDATA_W-1:0]    c0_rsp_mdata,
    output logic [511:0]          c0_rsp_data,
    input  logic                  c1_req_valid,
    input  logic [CL_ADDR_W-1:0]  c1_req_addr,
    input  logic [MDATA_W-1:0]    c1_req_mdata,
    input  logic [511:0]          c1_req_data,
    output logic                  c1_almfull,
    output logic                  c1_rsp_valid,
    output logic [MDATA_W-1:0]    c1_rsp_mdata,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [511:0]          dbg_data,
    output logic                  err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = $clog2(RD_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RD_LATENCY);
    localparam logic [CNT_W-1:0] CNT_THR = CNT_W'(ALMFULL_THR);

    logic [511:0]          r_mem [DEPTH];

    logic                  r_pv [RD_LATENCY];
    logic [MDATA_W-1:0]    r_pm [RD_LATENCY];
    logic [511:0]          r_pd [RD_LATENCY];

    logic [CNT_W-1:0]      r_inflight;
    logic                  r_almfull;
    logic                  r_c1_rsp_valid;
    logic [MDATA_W-1:0]    r_c1_rsp_mdata;

    logic [ADDR_WIDTH-1:0] w_rd_idx;
    logic [ADDR_WIDTH-1:0] w_wr_idx;
    logic                  w_rd_oor;
    logic                  w_wr_oor;
    logic [511:0]          w_rd_line;
    logic [CNT_W-1:0]      w_inflight_nxt;

    assign w_rd_idx = c0_req_addr[ADDR_WIDTH-1:0];
    assign w_wr_idx = c1_req_addr[ADDR_WIDTH-1:0];

`ifdef CCI_RSP_ADDR_CHECK_EN
    logic r_err;

    assign w_rd_oor = |c0_req_addr[CL_ADDR_W-1:ADDR_WIDTH];
    assign w_wr_oor = |c1_req_addr[CL_ADDR_W-1:ADDR_WIDTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if ((c0_req_valid && w_rd_oor) || (c1_req_valid && w_wr_oor)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    // Upper address bits are deliberately ignored; addresses wrap.
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^{c0_req_addr[CL_ADDR_W-1:ADDR_WIDTH],
                                c1_req_addr[CL_ADDR_W-1:ADDR_WIDTH]};
    assign w_rd_oor = 1'b0;
    assign w_wr_oor = 1'b0;
    assign err      = 1'b0;
`endif

    // The read samples memory before this edge's write lands, so a
    // same-cycle read and write to one line returns the old contents.
    assign w_rd_line = w_rd_oor ? '0 : r_mem[w_rd_idx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (c1_req_valid && !w_wr_oor) begin
            r_mem[w_wr_idx] <= c1_req_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_pv[i] <= 1'b0;
                r_pm[i] <= '0;
                r_pd[i] <= '0;
            end
        end else begin
            r_pv[0] <= c0_req_valid;
            r_pm[0] <= c0_req_mdata;
            r_pd[0] <= w_rd_line;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pm[i] <= r_pm[i-1];
                r_pd[i] <= r_pd[i-1];
            end
        end
    end

    assign c0_rsp_valid = r_pv[RD_LATENCY-1];
    assign c0_rsp_mdata = r_pm[RD_LATENCY-1];
    assign c0_rsp_data  = r_pd[RD_LATENCY-1];

    // The counter tracks accepted reads whose response has not yet been
    // presented. It is clamped at both ends so it can never wrap.
    always_comb begin
        w_inflight_nxt = r_inflight;
        if (c0_req_valid && !c0_rsp_valid) begin
            if (r_inflight != CNT_MAX) begin
                w_inflight_nxt = r_inflight + 1'b1;
            end
        end else if (!c0_req_valid && c0_rsp_valid) begin
            if (r_inflight != '0) begin
                w_inflight_nxt = r_inflight - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_inflight <= '0;
            r_almfull  <= 1'b0;
        end else begin
            r_inflight <= w_inflight_nxt;
            r_almfull  <= (w_inflight_nxt >= CNT_THR);
        end
    end

    assign c0_almfull = r_almfull;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_c1_rsp_valid <= 1'b0;
            r_c1_rsp_mdata <= '0;
        end else begin
            r_c1_rsp_valid <= c1_req_valid;
            r_c1_rsp_mdata <= c1_req_valid ? c1_req_mdata : '0;
        end
    end

    assign c1_rsp_valid = r_c1_rsp_valid;
    assign c1_rsp_mdata = r_c1_rsp_mdata;
    assign c1_almfull   = 1'b0;
    assign dbg_data     = r_mem[dbg_addr];

endmodule

// File: tb/tb_cci_host_mem_responder.sv
module tb_cci_host_mem_responder;

    logic         clk;
    logic         reset_n;
    logic         c0_req_valid;
    logic [41:0]  c0_req_addr;
    logic [15:0]  c0_req_mdata;
    logic         c0_almfull;
    logic         c0_rsp_valid;
    logic [15:0]  c0_rsp_mdata;
    logic [511:0] c0_rsp_data;
    logic         c1_req_valid;
    logic [41:0]  c1_req_addr;
    logic [15:0]  c1_req_mdata;
    logic [511:0] c1_req_data;
    logic         c1_almfull;
    logic         c1_rsp_valid;
    logic [15:0]  c1_rsp_mdata;
    logic [3:0]   dbg_addr;
    logic [511:0] dbg_data;
    logic         err;

    int checks = 0;
    int errors = 0;

    cci_host_mem_responder dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .c0_req_valid (c0_req_valid),
        .c0_req_addr  (c0_req_addr),
        .c0_req_mdata (c0_req_mdata),
        .c0_almfull   (c0_almfull),
        .c0_rsp_valid (c0_rsp_valid),
        .c0_rsp_mdata (c0_rsp_mdata),
        .c0_rsp_data  (c0_rsp_data),
        .c1_req_valid (c1_req_valid),
        .c1_req_addr  (c1_req_addr),
        .c1_req_mdata (c1_req_mdata),
        .c1_req_data  (c1_req_data),
        .c1_almfull   (c1_almfull),
        .c1_rsp_valid (c1_rsp_valid),
        .c1_rsp_mdata (c1_rsp_mdata),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data),
        .err          (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        c0_req_valid = 1'b0;
        c0_req_addr  = '0;
        c0_req_mdata = '0;
        c1_req_valid = 1'b0;
        c1_req_addr  = '0;
        c1_req_mdata = '0;
        c1_req_data  = '0;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        dbg_addr = 4'd3;
        idle_inputs();
        step();
        step();
        reset_n = 1'b1;
        step();
        checks++;
        if ({c0_rsp_valid, c1_rsp_valid, c0_almfull, c1_almfull, err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000",
                     {c0_rsp_valid, c1_rsp_valid, c0_almfull, c1_almfull, err});
        end
        checks++;
        if (c0_rsp_data !== 512'd0 || c0_rsp_mdata !== 16'd0 || c1_rsp_mdata !== 16'd0) begin
            errors++;
            $display("FAIL reset_data got data=%h mdata0=%h mdata1=%h want all zero",
                     c0_rsp_data[31:0], c0_rsp_mdata, c1_rsp_mdata);
        end
        checks++;
        if (dbg_data !== 512'd0) begin
            errors++;
            $display("FAIL reset_mem got %h want 0", dbg_data[63:0]);
        end
    endtask

    task automatic test_write_read();
        logic [511:0] line;
        line = {448'd0, 32'd35, 32'd1};
        c1_req_valid = 1'b1;
        c1_req_addr  = 42'd2;
        c1_req_mdata = 16'd5;
        c1_req_data  = line;
        step();
        idle_inputs();
        checks++;
        if (c1_rsp_valid !== 1'b1 || c1_rsp_mdata !== 16'd5) begin
            errors++;
            $display("FAIL wr_ack got v=%b m=%0d want v=1 m=5", c1_rsp_valid, c1_rsp_mdata);
        end
        dbg_addr = 4'd2;
        #1;
        checks++;
        if (dbg_data !== line) begin
            errors++;
            $display("FAIL wr_mem got %h want %h", dbg_data[63:0], line[63:0]);
        end
        c0_req_valid = 1'b1;
        c0_req_addr  = 42'd2;
        c0_req_mdata = 16'd9;
        step();
        idle_inputs();
        checks++;
        if (c1_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_ack_width got %b want 0", c1_rsp_valid);
        end
        for (int s = 1; s <= 5; s++) begin
            if (s > 1) step();
            checks++;
            if (c0_rsp_valid !== (s == 4)) begin
                errors++;
                $display("FAIL rd_latency step=%0d got %b want %b", s, c0_rsp_valid, (s == 4));
            end
            if (s == 4) begin
                checks++;
                if (c0_rsp_data !== line || c0_rsp_mdata !== 16'd9) begin
                    errors++;
                    $display("FAIL rd_data got %h m=%0d want %h m=9",
                             c0_rsp_data[63:0], c0_rsp_mdata, line[63:0]);
                end
            end
        end
    endtask

    task automatic test_collision();
        logic [511:0] old_l;
        logic [511:0] new_l;
        old_l = {64{8'h55}};
        new_l = {64{8'hAA}};
        c1_req_valid = 1'b1;
        c1_req_addr  = 42'd1;
        c1_req_data  = old_l;
        step();
        c1_req_data  = new_l;
        c0_req_valid = 1'b1;
        c0_req_addr  = 42'd1;
        c0_req_mdata = 16'd7;
        step();
        idle_inputs();
        dbg_addr = 4'd1;
        #1;
        checks++;
        if (dbg_data !== new_l) begin
            errors++;
            $display("FAIL coll_mem got %h want aa..", dbg_data[63:0]);
        end
        step();
        step();
        step();
        checks++;
        if (c0_rsp_valid !== 1'b1 || c0_rsp_data !== old_l || c0_rsp_mdata !== 16'd7) begin
            errors++;
            $display("FAIL coll_rd got v=%b %h m=%0d want v=1 55.. m=7",
                     c0_rsp_valid, c0_rsp_data[63:0], c0_rsp_mdata);
        end
        step();
    endtask

    task automatic test_streaming();
        logic [511:0] exp_l;
        for (int i = 0; i < 4; i++) begin
            c1_req_valid = 1'b1;
            c1_req_addr  = 42'(i);
            c1_req_mdata = 16'(16'h20 + i);
            c1_req_data  = {480'd0, 32'hC0DE0000 + 32'(i)};
            step();
            checks++;
            if (i > 0 && (c1_rsp_valid !== 1'b1 || c1_rsp_mdata !== 16'(16'h20 + i))) begin
                errors++;
                $display("FAIL b2b_wr_ack i=%0d got v=%b m=%h", i, c1_rsp_valid, c1_rsp_mdata);
            end
        end
        idle_inputs();
        step();
        for (int s = 1; s <= 8; s++) begin
            if (s <= 4) begin
                c0_req_valid = 1'b1;
                c0_req_addr  = 42'(s - 1);
                c0_req_mdata = 16'(s - 1);
            end else begin
                idle_inputs();
            end
            step();
            checks++;
            if (c0_almfull !== (s >= 2 && s <= 6)) begin
                errors++;
                $display("FAIL almfull step=%0d got %b want %b", s, c0_almfull, (s >= 2 && s <= 6));
            end
            checks++;
            if (c0_rsp_valid !== (s >= 4 && s <= 7)) begin
                errors++;
                $display("FAIL stream_valid step=%0d got %b", s, c0_rsp_valid);
            end
            if (s >= 4 && s <= 7) begin
                exp_l = {480'd0, 32'hC0DE0000 + 32'(s - 4)};
                checks++;
                if (c0_rsp_mdata !== 16'(s - 4) || c0_rsp_data !== exp_l) begin
                    errors++;
                    $display("FAIL stream_order step=%0d got m=%0d d=%h want m=%0d d=%h",
                             s, c0_rsp_mdata, c0_rsp_data[31:0], s - 4, exp_l[31:0]);
                end
            end
        end
    endtask

    task automatic test_range();
        logic [511:0] exp_l;
        logic         exp_err;
`ifdef CCI_RSP_ADDR_CHECK_EN
        exp_l   = '0;
        exp_err = 1'b1;
`else
        exp_l   = {480'd0, 32'hC0DE0000};
        exp_err = 1'b0;
`endif
        c0_req_valid = 1'b1;
        c0_req_addr  = 42'h10;
        c0_req_mdata = 16'hE;
        step();
        idle_inputs();
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL range_err got %b want %b", err, exp_err);
        end
        step();
        step();
        step();
        checks++;
        if (c0_rsp_valid !== 1'b1 || c0_rsp_data !== exp_l || c0_rsp_mdata !== 16'hE) begin
            errors++;
            $display("FAIL range_data got v=%b %h m=%h want %h",
                     c0_rsp_valid, c0_rsp_data[31:0], c0_rsp_mdata, exp_l[31:0]);
        end
        step();
    endtask

    task automatic test_reset_midflight();
        int seen;
        seen = 0;
        for (int i = 0; i < 2; i++) begin
            c0_req_valid = 1'b1;
            c0_req_addr  = 42'(i);
            c0_req_mdata = 16'(16'h40 + i);
            step();
        end
        idle_inputs();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({c0_rsp_valid, c1_rsp_valid, c0_almfull, err} !== 4'b0) begin
            errors++;
            $display("FAIL midreset_flags got %b want 0000",
                     {c0_rsp_valid, c1_rsp_valid, c0_almfull, err});
        end
        step();
        reset_n = 1'b1;
        dbg_addr = 4'd3;
        #1;
        checks++;
        if (dbg_data !== 512'd0) begin
            errors++;
            $display("FAIL midreset_mem got %h want 0", dbg_data[31:0]);
        end
        for (int s = 0; s < 10; s++) begin
            step();
            if (c0_rsp_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midreset_rsp got %0d responses want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_collision();
        test_streaming();
        test_range();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
